// File: rtl/axis_pixel_transmitter_if.sv
// AXI4-Stream video bus carried out of the pixel transmitter.
// Master drives payload/sideband, slave drives tready.
interface axis_pixel_transmitter_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tuser;
  logic                  tlast;

  modport master (
    output tdata,
    output tvalid,
    output tuser,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tuser,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_pixel_transmitter.sv
// Pixel stream to AXI4-Stream video, with frame/line tagging and a FWFT FIFO.
// Define AXIS_TX_OVERFLOW_EN to get a sticky o_overflow drop flag.
module axis_pixel_transmitter #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [11:0]                   IMAGE_WIDTH,
  input  logic [DATA_WIDTH-1:0]         i_data,
  input  logic                          i_data_valid,
  input  logic                          i_start_of_frame,
  axis_pixel_transmitter_if.master      m_axis,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [AW:0] FULL_LVL = FIFO_DEPTH[AW:0];

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [11:0]   col_q, col_d;
  logic [11:0]   width_q, width_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];

  logic          sof_acc;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          empty;
  logic          full;
  logic [11:0]   col_cur;
  logic [11:0]   width_cur;
  logic          tag_user;
  logic          tag_last;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_LVL);
  assign pop   = ~empty & m_axis.tready;

  assign sof_acc  = i_data_valid & i_start_of_frame;
  assign push_req = i_data_valid & (sof_acc | (state_q == S_ACTIVE));
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push     = push_req & (~full | pop);

  always_comb begin
    width_cur = width_q;
    col_cur   = col_q;
    tag_user  = 1'b0;
    if (sof_acc) begin
      width_cur = (IMAGE_WIDTH == 12'd0) ? 12'd1 : IMAGE_WIDTH;
      col_cur   = 12'd0;
      tag_user  = 1'b1;
    end
    tag_last = (col_cur == width_cur - 12'd1);
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    width_d = width_q;
    if (sof_acc) begin
      state_d = S_ACTIVE;
      width_d = width_cur;
    end
    // Column advances on drops too, so line geometry survives overflow.
    if (push_req) begin
      col_d = tag_last ? 12'd0 : col_cur + 12'd1;
    end
  end

  assign wr_entry = {tag_user, tag_last, i_data};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case (1'b1)
      (push & ~pop): count_d = count_q + 1'b1;
      (pop & ~push): count_d = count_q - 1'b1;
      default:       count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      col_q    <= '0;
      width_q  <= 12'd1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      width_q  <= width_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign head = mem_q[rd_ptr_q];

  assign m_axis.tvalid = ~empty;
  assign m_axis.tdata  = empty ? '0   : head[DATA_WIDTH-1:0];
  assign m_axis.tlast  = empty ? 1'b0 : head[DATA_WIDTH];
  assign m_axis.tuser  = empty ? 1'b0 : head[DATA_WIDTH+1];

  assign o_fifo_level = count_q;

`ifdef AXIS_TX_OVERFLOW_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q | (push_req & ~push);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end

  assign o_overflow = ovf_q;
`else
  assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_axis_pixel_transmitter.sv
// Scoreboard bench for axis_pixel_transmitter.
// Expected beats are queued at drive time and checked on handshake.
module tb_axis_pixel_transmitter;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [11:0]   img_w = 12'd8;
  logic [DW-1:0] din = '0;
  logic          dvalid = 1'b0;
  logic          dsof = 1'b0;
  logic [4:0]    lvl;
  logic          ovf;

  axis_pixel_transmitter_if #(.DATA_WIDTH(DW)) axis ();

  axis_pixel_transmitter #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .IMAGE_WIDTH      (img_w),
    .i_data           (din),
    .i_data_valid     (dvalid),
    .i_start_of_frame (dsof),
    .m_axis           (axis.master),
    .o_fifo_level     (lvl),
    .o_overflow       (ovf)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [9:0] exp_q [$];
  logic       m_act;
  logic [11:0] m_col, m_w;
  int         m_cnt;
  logic       m_ovf;
  logic       prev_stall;
  logic [9:0] prev_beat;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_act = 1'b0;
    m_col = '0;
    m_w   = 12'd1;
    m_cnt = 0;
    m_ovf = 1'b0;
    prev_stall = 1'b0;
    prev_beat  = '0;
  endtask

  // One cycle: drive at negedge, check 1ns later, advance model.
  task automatic step(input logic v, input logic s, input logic [7:0] d,
                      input logic rdy);
    logic       pop, acc, tu, tl;
    logic [11:0] c, w;
    logic [9:0] beat, e;
    @(negedge clk);
    dvalid = v;
    dsof   = s;
    din    = d;
    axis.tready = rdy;
    #1;
    beat = {axis.tuser, axis.tlast, axis.tdata};
    chk("tvalid", {31'd0, axis.tvalid}, {31'd0, m_cnt != 0});
    chk("level", {27'd0, lvl}, m_cnt);
`ifdef AXIS_TX_OVERFLOW_EN
    chk("overflow", {31'd0, ovf}, {31'd0, m_ovf});
`else
    chk("overflow", {31'd0, ovf}, 32'd0);
`endif
    if (prev_stall) begin
      chk("stall_valid", {31'd0, axis.tvalid}, 32'd1);
      chk("stall_beat", {22'd0, beat}, {22'd0, prev_beat});
    end
    pop = (m_cnt != 0) && rdy;
    if (pop) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", {22'd0, beat}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("beat", {22'd0, beat}, {22'd0, e});
      end
    end
    prev_stall = axis.tvalid && !rdy;
    prev_beat  = beat;
    if (v && (s || m_act)) begin
      if (s) begin
        w = (img_w == 0) ? 12'd1 : img_w;
        c = 12'd0;
        tu = 1'b1;
        m_w = w;
        m_act = 1'b1;
      end else begin
        w = m_w;
        c = m_col;
        tu = 1'b0;
      end
      tl = (c == w - 12'd1);
      m_col = tl ? 12'd0 : c + 12'd1;
      acc = (m_cnt < DEPTH) || pop;
      if (acc) exp_q.push_back({tu, tl, d});
      else     m_ovf = 1'b1;
      m_cnt = m_cnt + (acc ? 1 : 0);
    end
    m_cnt = m_cnt - (pop ? 1 : 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    dvalid = 1'b0;
    dsof = 1'b0;
    axis.tready = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_tvalid", {31'd0, axis.tvalid}, 32'd0);
    chk("rst_level", {27'd0, lvl}, 32'd0);
    chk("rst_beat", {22'd0, axis.tuser, axis.tlast, axis.tdata}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_cnt != 0 || exp_q.size() != 0) && n < 200) begin
      step(1'b0, 1'b0, 8'd0, 1'b1);
      n++;
    end
    chk("drain_left", exp_q.size(), 32'd0);
  endtask

  task automatic frame(input int npix, input logic [7:0] base,
                       input int rmode);
    logic r;
    for (int i = 0; i < npix; i++) begin
      r = (rmode == 0) ? 1'b1 : (rmode == 1) ? (i % 2 == 0) : 1'b0;
      step(1'b1, i == 0, base + 8'(i), r);
    end
  endtask

  initial begin
    axis.tready = 1'b0;
    model_clear();
    do_reset();

    img_w = 12'd8;
    frame(24, 8'd0, 0);
    drain();

    do_reset();
    frame(24, 8'd0, 1);
    drain();

    do_reset();
    frame(20, 8'd0, 2);
    chk("full_level", {27'd0, lvl}, 32'd16);
`ifdef AXIS_TX_OVERFLOW_EN
    chk("ovf_set", {31'd0, ovf}, 32'd1);
`endif
    drain();

    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(i), 1'b1);
    chk("no_sof_drop", {27'd0, lvl}, 32'd0);
    frame(8, 8'd4, 0);
    drain();

    do_reset();
    frame(5, 8'd0, 0);
    frame(9, 8'd50, 0);
    step(1'b0, 1'b1, 8'd0, 1'b1);
    drain();

    do_reset();
    frame(6, 8'd0, 2);
    do_reset();
    frame(10, 8'd100, 0);
    drain();

    do_reset();
    img_w = 12'd1;
    frame(3, 8'd20, 0);
    img_w = 12'd0;
    frame(3, 8'd30, 0);
    drain();

    do_reset();
    img_w = 12'd5;
    for (int i = 0; i < 40; i++)
      step($urandom_range(0, 3) != 0, i == 0, 8'($urandom_range(0, 255)),
           $urandom_range(0, 2) != 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
